// File: rtl/sm_accumulator_pkg.sv
// Shared types and constants for the sign-magnitude accumulator.
// Holds the FSM state encoding, 5-bit SM word constants and a normaliser.
package sm_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int          SM_W        = 5;
    localparam int          SM_MAG_W    = 4;
    localparam logic [3:0]  SM_MAG_MAX  = 4'hF;
    localparam logic [4:0]  SM_NEG_ZERO = 5'b10000;

    // Map -0 onto +0 so the adder never sees a signed zero.
    function automatic logic [SM_W-1:0] sm_norm(input logic [SM_W-1:0] x);
        return (x == SM_NEG_ZERO) ? '0 : x;
    endfunction

endpackage

// File: rtl/sm_adder_s.sv
// Combinational 5-bit sign-magnitude adder (bit 4 sign, bits 3:0 magnitude).
// Ports: a, b operands; sum result (never -0); ovflw same-sign carry out.
module sm_adder_s
    import sm_accumulator_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] sum,
    output logic            ovflw
);

    logic                sa;
    logic                sb;
    logic [SM_MAG_W-1:0] ma;
    logic [SM_MAG_W-1:0] mb;
    logic [SM_MAG_W:0]   mag_add;
    logic [SM_MAG_W-1:0] mag;
    logic                sgn;

    assign sa      = a[SM_W-1];
    assign sb      = b[SM_W-1];
    assign ma      = a[SM_MAG_W-1:0];
    assign mb      = b[SM_MAG_W-1:0];
    assign mag_add = {1'b0, ma} + {1'b0, mb};

    always_comb begin
        mag   = '0;
        sgn   = 1'b0;
        ovflw = 1'b0;
        if (sa == sb) begin
            mag   = mag_add[SM_MAG_W-1:0];
            sgn   = sa;
            ovflw = mag_add[SM_MAG_W];
        end else if (ma >= mb) begin
            mag = ma - mb;
            sgn = sa;
        end else begin
            mag = mb - ma;
            sgn = sb;
        end
        // A zero magnitude is always reported as +0.
        sum = {(sgn && (mag != '0)), mag};
    end

endmodule

// File: rtl/sm_accumulator.sv
// Multi-operand SM accumulator: sums N_OPS operands per batch via sm_adder_s.
// Ports: clk, rst_n, start; in_valid/in_data/in_ready input stream;
// out_valid/out_ready/acc_out result handshake; ovflw sticky flag; busy.
module sm_accumulator
    import sm_accumulator_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter bit SAT   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [SM_W-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SM_W-1:0] acc_out,
    output logic            ovflw,
    output logic            busy
);

    localparam logic [3:0] LAST = 4'(N_OPS - 1);

    state_t          state;
    logic [SM_W-1:0] acc;
    logic [3:0]      cnt;
    logic            ovf_q;

    logic [SM_W-1:0] operand;
    logic [SM_W-1:0] add_sum;
    logic            add_ovf;
    logic [SM_W-1:0] sel;
    logic [SM_W-1:0] acc_next;

    assign operand = sm_norm(in_data);

    sm_adder_s u_add (
        .a     (acc),
        .b     (operand),
        .sum   (add_sum),
        .ovflw (add_ovf)
    );

    // Overflow only happens with same-sign operands, so acc carries
    // the true sign even when the wrapped sum collapsed to +0.
    always_comb begin
        sel = add_sum;
        if (add_ovf && SAT)
            sel = {acc[SM_W-1], SM_MAG_MAX};
        acc_next = (sel[SM_MAG_W-1:0] == '0) ? '0 : sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt + 4'd1;
                        if (add_ovf)
                            ovf_q <= 1'b1;
                        if (cnt == LAST)
                            state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign acc_out   = acc;
    assign ovflw     = ovf_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Self-checking bench for sm_accumulator (SAT=1 and SAT=0 side by side).
// Directed and random batches checked against an integer reference model.
module tb_sm_accumulator;

    localparam int NOPS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       ir_s, ov_s, bz_s, of_s;
    logic [4:0] acc_s;
    logic       ir_w, ov_w, bz_w, of_w;
    logic [4:0] acc_w;

    int checks = 0;
    int failures = 0;

    sm_accumulator #(.N_OPS(NOPS), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_s),
        .out_valid(ov_s), .out_ready(out_ready),
        .acc_out(acc_s), .ovflw(of_s), .busy(bz_s)
    );

    sm_accumulator #(.N_OPS(NOPS), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_w),
        .out_valid(ov_w), .out_ready(out_ready),
        .acc_out(acc_w), .ovflw(of_w), .busy(bz_w)
    );

    always #5 clk = ~clk;

    function automatic int smv(input logic [4:0] x);
        return x[4] ? -int'(x[3:0]) : int'(x[3:0]);
    endfunction

    // Returns {overflow, new_acc} from integer arithmetic.
    function automatic logic [5:0] mstep(input logic [4:0] a,
                                         input logic [4:0] d,
                                         input bit sat);
        int s, m;
        bit ov, neg;
        s = smv(a) + smv(d);
        neg = (s < 0);
        m = neg ? -s : s;
        ov = (m > 15);
        if (ov) m = sat ? 15 : (m % 16);
        return {ov, (neg && m != 0), 4'(m)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic ir,
                           input logic ov, input logic bz);
        chk({tag, " ctl"}, {2'b0, ir_s, ov_s, bz_s, ir_w, ov_w, bz_w},
            {2'b0, ir, ov, bz, ir, ov, bz});
    endtask

    task automatic chk_res(input string tag,
                           input logic [4:0] es, input logic os,
                           input logic [4:0] ew, input logic ow);
        chk({tag, " sat"}, {2'b0, of_s, acc_s}, {2'b0, os, es});
        chk({tag, " wrap"}, {2'b0, of_w, acc_w}, {2'b0, ow, ew});
    endtask

    task automatic run_batch(input string tag, input logic [4:0] ops[NOPS],
                             input int stall_max, input int hold_wait,
                             input bit poke);
        logic [4:0] ms, mw;
        logic [5:0] r;
        bit os, ow;
        int st;
        ms = '0; mw = '0; os = 0; ow = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_ctl({tag, " startup"}, 1, 0, 1);
        for (int i = 0; i < NOPS; i++) begin
            st = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            for (int j = 0; j < st; j++) begin
                in_valid = 1'b0;
                in_data = 5'($urandom);
                start = poke;
                @(negedge clk);
                start = 1'b0;
                chk_ctl({tag, " stall"}, 1, 0, 1);
            end
            in_valid = 1'b1;
            in_data = ops[i];
            @(negedge clk);
            r = mstep(ms, ops[i], 1'b1);
            ms = r[4:0]; os = os | r[5];
            r = mstep(mw, ops[i], 1'b0);
            mw = r[4:0]; ow = ow | r[5];
            if (i < NOPS - 1) chk_ctl({tag, " accum"}, 1, 0, 1);
        end
        in_valid = 1'b0;
        chk_ctl({tag, " hold"}, 0, 1, 1);
        chk_res({tag, " result"}, ms, os, mw, ow);
        for (int k = 0; k < hold_wait; k++) begin
            in_valid = 1'b1;
            in_data = 5'($urandom);
            start = poke;
            @(negedge clk);
            start = 1'b0;
            chk_ctl({tag, " hold wait"}, 0, 1, 1);
            chk_res({tag, " hold stable"}, ms, os, mw, ow);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_ctl({tag, " idle"}, 0, 0, 0);
        chk_res({tag, " idle keep"}, ms, os, mw, ow);
        @(negedge clk);
        chk_ctl({tag, " idle2"}, 0, 0, 0);
    endtask

    initial begin
        logic [4:0] ops[NOPS];

        #2;
        chk_ctl("reset", 0, 0, 0);
        chk_res("reset", 5'b0, 0, 5'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_ctl("idle after reset", 0, 0, 0);

        ops = '{5'b00011, 5'b00101, 5'b10010, 5'b00001};
        run_batch("basic", ops, 0, 0, 0);
        run_batch("stalls", ops, 2, 3, 1);

        ops = '{5'b01001, 5'b01001, 5'b10001, 5'b00000};
        run_batch("saturate", ops, 0, 1, 0);

        ops = '{5'b10000, 5'b00100, 5'b10100, 5'b10000};
        run_batch("zero", ops, 0, 0, 0);

        // Reset in the middle of a batch.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 5'b01001;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("midreset", 0, 0, 0);
        chk_res("midreset", 5'b0, 0, 5'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_ctl("post reset idle", 0, 0, 0);
        ops = '{5'b11111, 5'b10001, 5'b00000, 5'b00000};
        run_batch("after reset", ops, 0, 0, 0);

        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < NOPS; i++) ops[i] = 5'($urandom);
            run_batch("random", ops, 2, int'($urandom_range(2, 0)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_accumulator.md
# sm_accumulator

Sequential sign-magnitude accumulator placed directly downstream of `sm_adder_s`. It consumes a stream of 5-bit sign-magnitude operands over a valid/ready handshake and sums a batch of `N_OPS` operands. Each partial sum is fed back through an internal `sm_adder_s` instance. The batch total and a sticky overflow flag are then presented on an output handshake. It turns the combinational adder into a multi-operand stage for the rest of the arithmetic datapath.

## Interface
- `N_OPS`, default 4: operands per batch; legal range 2–16.
- `SAT`, default 1: 1 saturates to ±15 on overflow; 0 keeps the wrapped adder result.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begins a batch; honoured only in IDLE.
- `in_valid`, input, 1: `in_data` is valid.
- `in_data`, input, 5: operand; bit 4 = sign (1 = negative), bits 3:0 = magnitude.
- `in_ready`, output, 1: accumulator accepts `in_data` this cycle.
- `out_valid`, output, 1: `acc_out` holds a completed batch total.
- `out_ready`, input, 1: consumer takes `acc_out`.
- `acc_out`, output, 5: accumulated sign-magnitude total.
- `ovflw`, output, 1: sticky overflow for the current or last batch.
- `busy`, output, 1: high in ACCUM or HOLD.

## Operation
- FSM states are IDLE, ACCUM and HOLD.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - On `start`=1: `acc`←+0 (5'b00000), `cnt`←0, `ovflw`←0, next state ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On `in_valid` & `in_ready`: `acc`←f(`acc` + `in_data`), `cnt`←`cnt`+1.
  - If `cnt`==`N_OPS`−1 at that beat, next state HOLD. `in_valid`=0 cycles stall without effect.
- **HOLD**
  - `out_valid`=1, `in_ready`=0; `acc_out` and `ovflw` stay stable.
  - On `out_ready`=1, next state IDLE.
- `start` is ignored in ACCUM and HOLD.
- **Arithmetic**
  - The adder operands are `acc` and the normalised `in_data`.
  - Normalisation: an input of −0 (5'b10000) is treated as +0.
  - Sum sign and magnitude follow sign-magnitude rules; the result is never −0.
  - Overflow is the adder's OVFLW: a same-sign magnitude sum greater than 15.
- **Overflow handling**
  - `SAT`=1: `acc`←{sum sign, 4'hF}.
  - `SAT`=0: `acc`←adder SUM (low 4 bits wrapped).
  - If the wrapped magnitude is 0, sign is forced to +.
- `ovflw` is set on any overflowing beat and cleared only by `start` in IDLE or by reset.
- `acc_out` always reflects `acc`. It is meaningful only while `out_valid`=1.
- The last value in `acc_out` remains visible in IDLE until the next `start`.

## Timing
- **Reset** (asynchronous assert, synchronous deassert handled upstream):
  - state=IDLE, `acc`=0, `cnt`=0.
  - `acc_out`=5'b00000, `ovflw`=0, `out_valid`=0, `in_ready`=0, `busy`=0.
- **Reset mid-batch:** the batch is aborted and no `out_valid` is produced. After release the block waits for a fresh `start`.
- **Start-up latency:** `start` sampled at edge k gives `in_ready`=1 in cycle k+1.
- **Throughput:** one operand per cycle while `in_valid` stays high.
- **Result latency:** the final beat accepted at edge k gives `out_valid`=1 with the final `acc_out` in cycle k+1.
- **Output handshake:** `out_ready` accepted at edge m gives IDLE (`out_valid`=0) in cycle m+1.
  - `start` can be honoured at edge m+1 at the earliest.
- `in_ready` and `out_valid` are decoded from state only. There is no combinational path from `in_valid`/`out_ready` to them.
- `out_ready` is a don't-care outside HOLD; `in_valid` is a don't-care outside ACCUM.

## Structure
- A shared package holds:
  - the FSM state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - the constants `SM_W`=5, `SM_MAG_W`=4, `SM_MAG_MAX`=4'hF, `SM_NEG_ZERO`=5'b10000.
- One sub-module: the existing `sm_adder_s`, instantiated once with a=`acc`, b=normalised `in_data`.
- Normalisation, saturation select, counter and FSM live in `sm_accumulator`.
- `cnt` width is 4 bits.

## Test plan
- **Basic sum** (`N_OPS`=4, `SAT`=1): start; then +3, +5, −2, +1 back-to-back → `out_valid` the cycle after the 4th beat, `acc_out`=+7 (5'b00111), `ovflw`=0.
- **Saturation** (`SAT`=1): +9, +9, −1, +0 → `acc_out`=+14 (5'b01110), `ovflw`=1.
  - Same stimulus with `SAT`=0 → `acc_out`=+1, `ovflw`=1.
- **Zero handling:** −0, +4, −4, −0 → `acc_out`=+0 (5'b00000), never 5'b10000; `ovflw`=0.
- **Back-pressure and stalls:**
  - `in_valid` low for 2 cycles between beats → the same result as the basic sum.
  - `out_ready` held low 3 cycles in HOLD → `acc_out`/`out_valid` stable.
  - `start` pulsed during HOLD → ignored.
- **Reset mid-batch:** `rst_n`=0 after 2 beats → all outputs 0 immediately, state IDLE. After a new start and −15, −1, +0, +0 → `acc_out`=−15 (5'b11111), `ovflw`=1 (`SAT`=1).
